// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        WAIT_RSP = 2'd1,
        DRAIN    = 2'd2,
        HALT     = 2'd3
    } fetch_state_e;

    localparam logic [1:0] PC_ADV  = 2'b00;
    localparam logic [1:0] PC_LOAD = 2'b01;
    localparam logic [1:0] PC_HOLD = 2'b10;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: accepted fetches, redirects and stalled cycles.
// Counters wrap at 2^32.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_evt,
    input  logic        redirect_evt,
    input  logic        stall_evt,
    output logic [31:0] fetch_cnt,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (fetch_evt)    fetch_cnt    <= fetch_cnt + 32'd1;
            if (redirect_evt) redirect_cnt <= redirect_cnt + 32'd1;
            if (stall_evt)    stall_cnt    <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding fetch, one-entry decode buffer,
// EX redirects, stalls and halt at HALT_PC. Counters enabled by FETCH_PERF_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  HALT_PC  = ADDR_W'(800),
    parameter logic [31:0]        NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [1:0]        pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              stall,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_gnt,
    input  logic              im_rvalid,
    input  logic [31:0]       im_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              id_ready,
    output logic              halted,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_redirect_cnt,
    output logic [31:0]       perf_stall_cnt,
    output fetch_state_e      dbg_state
);

    // Handshakes: a fetch is accepted in a cycle with im_req && im_gnt; the
    // buffered instruction transfers to decode in a cycle with inst_valid &&
    // id_ready, and holds its contents while inst_valid && !id_ready.
    fetch_state_e      state_q, state_d;
    logic              halt_flag_q, halt_flag_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              buf_free;
    logic              fetch_go;

    assign buf_free = !inst_valid_q || id_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ISSUE;
            halt_flag_q  <= 1'b0;
            req_pc_q     <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            halt_flag_q  <= halt_flag_d;
            req_pc_q     <= req_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        halt_flag_d  = halt_flag_q;
        req_pc_d     = req_pc_q;
        inst_valid_d = inst_valid_q && !id_ready;
        inst_d       = (inst_valid_q && !id_ready) ? inst_q : NOP_INST;
        inst_pc_d    = inst_pc_q;
        pc_sel       = PC_HOLD;
        pc_target    = '0;
        im_req       = 1'b0;
        im_addr      = pc_in;
        fetch_go     = 1'b0;

        // A redirect flushes the buffer in every state
        if (redirect_valid) begin
            pc_sel       = PC_LOAD;
            pc_target    = redirect_target;
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
        end

        case (state_q)
            ISSUE: begin
                if (!redirect_valid && !stall && buf_free) begin
                    im_req = 1'b1;
                    if (im_gnt) begin
                        fetch_go    = 1'b1;
                        pc_sel      = PC_ADV;
                        req_pc_d    = pc_in;
                        halt_flag_d = (pc_in == HALT_PC);
                        state_d     = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (redirect_valid) begin
                    state_d = im_rvalid ? ISSUE : DRAIN;
                end else if (im_rvalid) begin
                    inst_valid_d = 1'b1;
                    inst_d       = im_rdata;
                    inst_pc_d    = req_pc_q;
                    state_d      = halt_flag_q ? HALT : ISSUE;
                end
            end
            DRAIN: begin
                // The squashed response is dropped; a new redirect only retargets
                if (im_rvalid) state_d = ISSUE;
            end
            HALT: begin
                if (redirect_valid) state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase

        if (!rst) begin
            im_req    = 1'b0;
            pc_sel    = PC_HOLD;
            pc_target = '0;
            fetch_go  = 1'b0;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign halted     = (state_q == HALT);
    assign dbg_state  = state_q;

`ifdef FETCH_PERF_EN
    fetch_perf_cnt u_perf (
        .clk          (clk),
        .rst          (rst),
        .fetch_evt    (fetch_go),
        .redirect_evt (redirect_valid),
        .stall_evt    (stall && (state_q != HALT)),
        .fetch_cnt    (perf_fetch_cnt),
        .redirect_cnt (perf_redirect_cnt),
        .stall_cnt    (perf_stall_cnt)
    );
`else
    assign perf_fetch_cnt    = '0;
    assign perf_redirect_cnt = '0;
    assign perf_stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed steps then random traffic, checked against a
// transaction-level model of the fetch stream, decode buffer and memory.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] HALT_PC = 32'd800;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  pc_in;
    logic [1:0]   pc_sel;
    logic [31:0]  pc_target;
    logic         redirect_valid;
    logic [31:0]  redirect_target;
    logic         stall;
    logic         im_req;
    logic [31:0]  im_addr;
    logic         im_gnt;
    logic         im_rvalid;
    logic [31:0]  im_rdata;
    logic         inst_valid;
    logic [31:0]  inst;
    logic [31:0]  inst_pc;
    logic         id_ready;
    logic         halted;
    logic [31:0]  perf_fetch_cnt;
    logic [31:0]  perf_redirect_cnt;
    logic [31:0]  perf_stall_cnt;
    fetch_state_e dbg_state;

    fetch_ctrl #(.ADDR_W(32), .HALT_PC(HALT_PC), .NOP_INST(NOP)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_in             (pc_in),
        .pc_sel            (pc_sel),
        .pc_target         (pc_target),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .stall             (stall),
        .im_req            (im_req),
        .im_addr           (im_addr),
        .im_gnt            (im_gnt),
        .im_rvalid         (im_rvalid),
        .im_rdata          (im_rdata),
        .inst_valid        (inst_valid),
        .inst              (inst),
        .inst_pc           (inst_pc),
        .id_ready          (id_ready),
        .halted            (halted),
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_stall_cnt    (perf_stall_cnt),
        .dbg_state         (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec;
    int n_miss;

    // Model: outstanding fetch, buffer contents (exp_q), architectural stream
    bit          out_v, out_sq, in_halt;
    logic [31:0] out_addr, arch_pc;
    logic [31:0] exp_q[$];
    logic [31:0] m_fetch, m_redir, m_stall;
    // Memory responder
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        stall = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = '0; pc_in = '0;
        #1;
        chk("rst_im_req", im_req, 0);
        chk("rst_pc_sel", pc_sel, PC_HOLD);
        chk("rst_pc_target", pc_target, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, NOP);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_state", dbg_state, ISSUE);
        chk("rst_perf_fetch", perf_fetch_cnt, 0);
        chk("rst_perf_redir", perf_redirect_cnt, 0);
        chk("rst_perf_stall", perf_stall_cnt, 0);
        out_v = 0; out_sq = 0; in_halt = 0; arch_pc = '0; exp_q.delete();
        m_fetch = '0; m_redir = '0; m_stall = '0;
        repeat (n) begin
            @(posedge clk); #1;
            if (mem_busy) begin
                if (mem_cnt > 0) mem_cnt--;
                else mem_busy = 0;
            end
        end
        rst = 1'b1;
    endtask

    task automatic run_cycle(input bit st, input bit rdy, input bit redir,
                             input logic [31:0] tgt, input bit gnt_ok, input int lat);
        bit          exp_req, grant, rsp_ok, was_halt;
        logic [1:0]  exp_sel;
        logic [31:0] pc_next;
        stall = st; id_ready = rdy; redirect_valid = redir; redirect_target = tgt;
        im_rvalid = mem_busy && (mem_cnt == 0);
        im_rdata  = im_rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        im_gnt    = 1'b0;
        #1;
        im_gnt = gnt_ok && im_req;
        #1;
        exp_req = !out_v && !in_halt && !st && !redir && (exp_q.size() == 0 || rdy);
        grant   = exp_req && gnt_ok;
        exp_sel = redir ? PC_LOAD : (grant ? PC_ADV : PC_HOLD);
        chk("im_req", im_req, exp_req);
        if (exp_req) chk("im_addr", im_addr, pc_in);
        chk("pc_sel", pc_sel, exp_sel);
        if (redir) chk("pc_target", pc_target, tgt);
        chk("inst_valid", inst_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("inst_pc", inst_pc, exp_q[0]);
            chk("inst", inst, mem_word(exp_q[0]));
        end else begin
            chk("inst_nop", inst, NOP);
        end
        chk("halted", halted, in_halt);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_redir", perf_redirect_cnt, m_redir);
        chk("perf_stall", perf_stall_cnt, m_stall);
`else
        chk("perf_fetch", perf_fetch_cnt, 0);
        chk("perf_redir", perf_redirect_cnt, 0);
        chk("perf_stall", perf_stall_cnt, 0);
`endif
        was_halt = in_halt;
        rsp_ok   = im_rvalid && out_v && !out_sq && !redir;
        if (rdy && !redir && exp_q.size() != 0) begin
            chk("arch_pc", exp_q[0], arch_pc);
            arch_pc = exp_q[0] + 32'd4;
            void'(exp_q.pop_front());
        end
        if (redir) begin
            exp_q.delete();
            in_halt = 0;
            arch_pc = tgt;
            out_sq  = 1;
        end
        if (im_rvalid && out_v) out_v = 0;
        if (rsp_ok) begin
            exp_q.push_back(out_addr);
            if (out_addr == HALT_PC) in_halt = 1;
        end
        if (im_rvalid) mem_busy = 0;
        if (grant) begin
            out_v = 1; out_sq = 0; out_addr = im_addr;
            mem_busy = 1; mem_cnt = lat; mem_addr = im_addr;
            m_fetch++;
        end
        if (redir) m_redir++;
        if (st && !was_halt) m_stall++;
        pc_next = (pc_sel == PC_ADV) ? pc_in + 32'd4 : (pc_sel == PC_LOAD) ? pc_target : pc_in;
        @(posedge clk); #1;
        pc_in = pc_next;
        if (mem_busy && mem_cnt > 0) mem_cnt--;
    endtask

    initial begin
        logic [31:0] tgt;
        n_vec = 0; n_miss = 0; mem_busy = 0; mem_cnt = 0; mem_addr = '0; out_addr = '0;
        #2;
        do_reset(3);

        // First fetch: 1-cycle memory, instruction visible two cycles after grant
        run_cycle(0, 1, 0, 0, 1, 1);
        run_cycle(0, 1, 0, 0, 0, 1);
        chk("tp1_valid", inst_valid, 1);
        chk("tp1_inst", inst, 32'h0050_0093);
        chk("tp1_pc", inst_pc, 0);

        // Decode back-pressure for 3 cycles, then release
        repeat (3) run_cycle(0, 0, 0, 0, 1, 1);
        chk("tp2_hold", inst, 32'h0050_0093);
        run_cycle(0, 1, 0, 0, 0, 1);

        // Redirect while waiting: response dropped, next fetch from 0x40
        run_cycle(0, 1, 0, 0, 1, 2);
        run_cycle(0, 1, 1, 32'h40, 0, 1);
        chk("tp3_drain", dbg_state, DRAIN);
        run_cycle(0, 1, 0, 0, 0, 1);
        chk("tp3_dropped", inst_valid, 0);
        chk("tp3_addr", im_addr, 32'h40);
        run_cycle(0, 1, 0, 0, 1, 1);
        run_cycle(0, 1, 0, 0, 0, 1);
        chk("tp3_inst_pc", inst_pc, 32'h40);

        // Redirect coinciding with the response
        run_cycle(0, 1, 0, 0, 1, 1);
        run_cycle(0, 1, 1, 32'h80, 0, 1);
        chk("tp4_state", dbg_state, ISSUE);
        chk("tp4_dropped", inst_valid, 0);

        // Halt at HALT_PC, then leave by redirect
        run_cycle(0, 1, 1, HALT_PC, 0, 1);
        run_cycle(0, 1, 0, 0, 1, 1);
        run_cycle(0, 1, 0, 0, 0, 1);
        chk("tp5_halted", halted, 1);
        chk("tp5_inst_pc", inst_pc, HALT_PC);
        repeat (3) run_cycle(0, 0, 0, 0, 1, 1);
        run_cycle(0, 1, 0, 0, 1, 1);
        chk("tp5_still_halted", halted, 1);
        run_cycle(0, 0, 1, 32'h100, 0, 1);
        chk("tp5_unhalt", halted, 0);

        // Reset mid-fetch; the late response must be ignored
        run_cycle(0, 1, 0, 0, 1, 3);
        do_reset(1);
        run_cycle(0, 1, 0, 0, 0, 1);
        run_cycle(0, 1, 0, 0, 0, 1);
        chk("late_rvalid", inst_valid, 0);

        // Counters: 5 grants, 3 stall cycles, 2 redirects
        do_reset(2);
        repeat (5) begin
            run_cycle(0, 1, 0, 0, 1, 1);
            run_cycle(0, 1, 0, 0, 0, 1);
        end
        repeat (3) run_cycle(1, 1, 0, 0, 1, 1);
        run_cycle(0, 1, 1, 32'h200, 0, 1);
        run_cycle(0, 1, 1, 32'h204, 0, 1);
`ifdef FETCH_PERF_EN
        chk("tp6_fetch", perf_fetch_cnt, 5);
        chk("tp6_redir", perf_redirect_cnt, 2);
        chk("tp6_stall", perf_stall_cnt, 3);
`else
        chk("tp6_fetch", perf_fetch_cnt, 0);
        chk("tp6_redir", perf_redirect_cnt, 0);
        chk("tp6_stall", perf_stall_cnt, 0);
`endif

        // Random traffic
        repeat (800) begin
            case ($urandom_range(0, 3))
                0:       tgt = HALT_PC;
                1:       tgt = HALT_PC - 32'd8;
                default: tgt = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            endcase
            run_cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 70,
                      $urandom_range(0, 99) < 6, tgt, $urandom_range(0, 99) < 75,
                      int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
